store_ctrl: RTL and testbench

//   Control FSM for the ST instruction: writes register R[src_sel] to memory at the address held in R[addr_sel].

---
 rtl/store_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_store_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/store_ctrl.sv
// store_ctrl: control FSM for the ST instruction. Writes R[src_sel] to memory at the address held
// in R[addr_sel]. The shared 16-bit bus is sequenced register -> MAR, then register -> MDR. The
// MEM_EN/MEM_RW/MFC write handshake follows, and the FSM finishes with a one-cycle done pulse.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   start         in   one-cycle request from the decoder, sampled only in IDLE
//   src_sel[1:0]  in   data register index, latched on an accepted start
//   addr_sel[1:0] in   address register index, latched on an accepted start
//   MFC           in   memory function complete
//   R_read[3:0]   out  one-hot register bus-drive enables [R3..R0]
//   MAR_write     out  MAR loads from bus
//   MAR_mem_read  out  MAR drives memory address
//   MDR_read      out  MDR loads from bus
//   MDR_mem_write out  MDR drives memory write data
//   MEM_EN        out  memory enable
//   MEM_RW        out  memory direction (RW_WRITE while writing)
//   busy          out  high in any state other than IDLE
//   done          out  one-cycle completion pulse
//   err           out  qualifies done: 1 = MFC timeout, write not confirmed
module store_ctrl #(
  parameter int unsigned MFC_TIMEOUT = 16,   // max WRITE cycles; 0 = wait forever
  parameter logic        RW_WRITE    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] src_sel,
  input  logic [1:0] addr_sel,
  input  logic       MFC,
  output logic [3:0] R_read,
  output logic       MAR_write,
  output logic       MAR_mem_read,
  output logic       MDR_read,
  output logic       MDR_mem_write,
  output logic       MEM_EN,
  output logic       MEM_RW,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {StIdle, StAddr, StData, StWrite, StDone} state_e;

  // Last counter value before giving up; only meaningful when MFC_TIMEOUT != 0.
  localparam logic [4:0] TimeoutLast = 5'(MFC_TIMEOUT - 1);

  state_e     r_state, w_state_next;
  logic [4:0] r_cnt, w_cnt_next;
  logic [1:0] r_src, w_src_next;
  logic [1:0] r_addr, w_addr_next;
  logic       w_err_next;

  logic [3:0] r_r_read, w_r_read;
  logic       r_mar_write, w_mar_write;
  logic       r_mar_mem_read, w_mar_mem_read;
  logic       r_mdr_read, w_mdr_read;
  logic       r_mdr_mem_write, w_mdr_mem_write;
  logic       r_mem_en, w_mem_en;
  logic       r_mem_rw, w_mem_rw;
  logic       r_busy, w_busy;
  logic       r_done, w_done;
  logic       r_err, w_err;

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_src_next   = r_src;
    w_addr_next  = r_addr;
    w_err_next   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_src_next   = src_sel;
          w_addr_next  = addr_sel;
          w_state_next = StAddr;
        end
      end
      StAddr: w_state_next = StData;
      StData: begin
        w_cnt_next   = 5'd0;
        w_state_next = StWrite;
      end
      StWrite: begin
        if (MFC) begin
          w_cnt_next   = 5'd0;
          w_state_next = StDone;
        end else if ((MFC_TIMEOUT != 0) && (r_cnt == TimeoutLast)) begin
          w_cnt_next   = 5'd0;
          w_err_next   = 1'b1;
          w_state_next = StDone;
        end else begin
          w_cnt_next = r_cnt + 5'd1;
        end
      end
      StDone: begin
        w_cnt_next   = 5'd0;
        w_state_next = StIdle;
      end
      default: begin
        w_cnt_next   = 5'd0;
        w_state_next = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state.
  // The selects are taken from their next values because ADDR must drive the freshly latched one.
  always_comb begin
    w_r_read        = 4'b0000;
    w_mar_write     = 1'b0;
    w_mar_mem_read  = 1'b0;
    w_mdr_read      = 1'b0;
    w_mdr_mem_write = 1'b0;
    w_mem_en        = 1'b0;
    w_mem_rw        = ~RW_WRITE;
    w_busy          = (w_state_next != StIdle);
    w_done          = 1'b0;
    w_err           = 1'b0;
    unique case (w_state_next)
      StAddr: begin
        w_r_read    = 4'b0001 << w_addr_next;
        w_mar_write = 1'b1;
      end
      StData: begin
        w_r_read   = 4'b0001 << w_src_next;
        w_mdr_read = 1'b1;
      end
      StWrite: begin
        w_mem_en        = 1'b1;
        w_mem_rw        = RW_WRITE;
        w_mar_mem_read  = 1'b1;
        w_mdr_mem_write = 1'b1;
      end
      StDone: begin
        w_done = 1'b1;
        w_err  = w_err_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= StIdle;
      r_cnt           <= 5'd0;
      r_src           <= 2'd0;
      r_addr          <= 2'd0;
      r_r_read        <= 4'b0000;
      r_mar_write     <= 1'b0;
      r_mar_mem_read  <= 1'b0;
      r_mdr_read      <= 1'b0;
      r_mdr_mem_write <= 1'b0;
      r_mem_en        <= 1'b0;
      r_mem_rw        <= ~RW_WRITE;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_cnt           <= w_cnt_next;
      r_src           <= w_src_next;
      r_addr          <= w_addr_next;
      r_r_read        <= w_r_read;
      r_mar_write     <= w_mar_write;
      r_mar_mem_read  <= w_mar_mem_read;
      r_mdr_read      <= w_mdr_read;
      r_mdr_mem_write <= w_mdr_mem_write;
      r_mem_en        <= w_mem_en;
      r_mem_rw        <= w_mem_rw;
      r_busy          <= w_busy;
      r_done          <= w_done;
      r_err           <= w_err;
    end
  end

  assign R_read        = r_r_read;
  assign MAR_write     = r_mar_write;
  assign MAR_mem_read  = r_mar_mem_read;
  assign MDR_read      = r_mdr_read;
  assign MDR_mem_write = r_mdr_mem_write;
  assign MEM_EN        = r_mem_en;
  assign MEM_RW        = r_mem_rw;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

endmodule

// File: tb/tb_store_ctrl.sv
// Testbench for store_ctrl. A bus/memory environment gives the register file, MAR/MDR and
// memory words. A driver issues stores and pushes the expected outcome of each one into a
// scoreboard queue. A monitor pops and checks the queue when done is seen.
module tb_store_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] src_sel, addr_sel;
  logic       MFC;
  logic [3:0] R_read;
  logic       MAR_write, MAR_mem_read, MDR_read, MDR_mem_write;
  logic       MEM_EN, MEM_RW, busy, done, err;

  store_ctrl #(.MFC_TIMEOUT(16), .RW_WRITE(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .src_sel(src_sel), .addr_sel(addr_sel),
    .MFC(MFC), .R_read(R_read), .MAR_write(MAR_write), .MAR_mem_read(MAR_mem_read),
    .MDR_read(MDR_read), .MDR_mem_write(MDR_mem_write), .MEM_EN(MEM_EN), .MEM_RW(MEM_RW),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;     // cycle count right after the accepting edge
    logic [1:0] src;
    logic [1:0] addr;
    logic [15:0] data;
    logic [15:0] adr;
    int         wcyc;  // expected number of WRITE cycles
    logic       err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          viol = 0;
  int          en_cnt = 0;
  int          wcnt = 0;
  int          cur_delay = 0;
  logic [15:0] regf [4];
  logic [15:0] mar, mdr;
  logic [15:0] mem [logic [15:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory commits the write on the edge where MFC is sampled.
  always @(posedge clk) begin
    if (!reset && MEM_EN && MEM_RW == 1'b0 && MAR_mem_read && MDR_mem_write && MFC)
      mem[mar] = mdr;
  end

  // Bus: registers drive the bus; MAR/MDR load from it.
  always @(negedge clk) begin
    if (MAR_write) mar = regf[onehot_idx(R_read)];
    if (MDR_read)  mdr = regf[onehot_idx(R_read)];
  end

  // Memory response: MFC rises after cur_delay WRITE cycles; random noise outside WRITE.
  always @(negedge clk) begin
    if (MEM_EN) begin
      wcnt++;
      MFC = (wcnt > cur_delay);
    end else begin
      wcnt = 0;
      MFC = 1'($urandom_range(0, 1));
    end
  end

  // Monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if ($countones(R_read) > 1 || (R_read != 4'b0 && MEM_EN)) viol++;
      if (MEM_EN) en_cnt++;
      if (sb.size() > 0) begin
        exp_t e;
        int   rel;
        e   = sb[0];
        rel = cyc - e.k;
        if (rel == 0) begin
          en_cnt = 0;
          chk("addr_phase", {R_read, MAR_write, MDR_read, MEM_EN},
              {4'b0001 << e.addr, 1'b1, 1'b0, 1'b0});
        end
        if (rel == 1)
          chk("data_phase", {R_read, MAR_write, MDR_read, MEM_EN},
              {4'b0001 << e.src, 1'b0, 1'b1, 1'b0});
        if (done) begin
          chk("err", 32'(err), 32'(e.err));
          chk("latency", rel, 2 + e.wcyc);
          chk("mem_en_cycles", en_cnt, e.wcyc);
          if (!e.err)
            chk("mem_word", mem.exists(e.adr) ? {16'h0, mem[e.adr]} : 32'h1_0000, 32'(e.data));
          else
            chk("no_write_on_timeout", 32'(mem.exists(e.adr)), 0);
          void'(sb.pop_front());
        end else if (rel > 40) begin
          chk("done_timeout", 0, 1);
          void'(sb.pop_front());
        end
      end else if (done) begin
        chk("spurious_done", 32'(done), 0);
      end
    end
  end

  task automatic issue(input logic [1:0] s, input logic [1:0] a, input int delay,
                       input bit overlap);
    exp_t e;
    for (int i = 0; i < 4; i++) regf[i] = 16'($urandom);
    mem.delete(regf[a]);
    cur_delay = delay;
    @(negedge clk);
    start = 1'b1; src_sel = s; addr_sel = a;
    @(posedge clk); #1;
    e.k = cyc; e.src = s; e.addr = a; e.data = regf[s]; e.adr = regf[a];
    e.wcyc = (delay < 16) ? delay + 1 : 16;
    e.err  = (delay >= 16);
    sb.push_back(e);
    start = 1'b0; src_sel = ~s; addr_sel = ~a;
    if (overlap) begin
      @(posedge clk); #1;                 // now in DATA
      start = 1'b1; src_sel = s + 2'd1; addr_sel = a + 2'd3;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 40 && !done; i++) @(negedge clk);
      start = 1'b1; src_sel = ~s; addr_sel = s;  // coincident with done
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("overlap_ignored_busy", 32'(busy), 0);
    end else begin
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (!busy && sb.size() == 0) break;
      end
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b1; src_sel = 2'd3; addr_sel = 2'd2;
    for (int i = 0; i < 4; i++) regf[i] = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy_with_start", 32'(busy), 0);
    chk("reset_outputs", {R_read, MEM_EN, MEM_RW, done, err}, {4'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", {R_read, MEM_EN, MEM_RW, busy, done},
        {4'b0, 1'b0, 1'b1, 1'b0, 1'b0});

    issue(2'd2, 2'd1, 0, 1'b0);   // basic store, MFC high at once
    issue(2'd0, 2'd3, 3, 1'b0);   // slow memory
    issue(2'd1, 2'd2, 99, 1'b0);  // timeout
    issue(2'd3, 2'd3, 1, 1'b0);   // src == addr
    issue(2'd1, 2'd0, 2, 1'b1);   // overlap in DATA and DONE

    // Reset in the middle of a write.
    for (int i = 0; i < 4; i++) regf[i] = 16'($urandom);
    cur_delay = 99;
    @(negedge clk);
    start = 1'b1; src_sel = 2'd0; addr_sel = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10 && !MEM_EN; i++) @(negedge clk);
    chk("write_reached", 32'(MEM_EN), 1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {MEM_EN, MEM_RW, busy, done}, {1'b0, 1'b1, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    issue(2'd3, 2'd0, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      int d;
      d = ($urandom_range(0, 5) == 0) ? 99 : int'($urandom_range(0, 5));
      issue(2'($urandom), 2'($urandom), d, 1'($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("bus_contention", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
